weighted_round_robin_arbiter: RTL and testbench

N-way weighted round-robin arbiter with a valid/ready output handshake. Each requester may hold the grant for up to `weights[i]` consecutive accepted transfers (one tenure) before priority rotates. It is the parametrised successor of the two-request round-robin arbiter and fronts shared resources such as a bus, memory port or output queue where requesters need unequal bandwidth shares.

---
 rtl/arb_pkg.sv | 20 ++
 rtl/fixed_arbiter.sv | 13 +
 rtl/weighted_round_robin_arbiter.sv | 99 +++++++++
 tb/tb_weighted_round_robin_arbiter.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared helpers for the weighted round-robin arbiter: one-hot decode and weight clamping.
package arb_pkg;

  localparam int unsigned MaxN = 32;

  // Callers zero-extend their N-bit one-hot vector to MaxN bits.
  function automatic int unsigned onehot_to_idx(input logic [MaxN-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MaxN; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

  function automatic int unsigned eff_weight(input int unsigned w);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/fixed_arbiter.sv
// Fixed-priority arbiter: grants the lowest-indexed active request.
module fixed_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);

  always_comb begin
    gnt_o = req_i & ~(req_i - N'(1));
  end

endmodule

// File: rtl/weighted_round_robin_arbiter.sv
// N-way weighted round-robin arbiter; each requester keeps the grant for up to its
// weight in accepted transfers before priority rotates past it.
module weighted_round_robin_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned WW  = 4,
  parameter int unsigned IDW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  requests,
  input  logic [N*WW-1:0] weights,
  input  logic          grant_ready,
  output logic [N-1:0]  grants,
  output logic          grant_valid,
  output logic [IDW-1:0] grant_id
);

  logic [N-1:0]   ptr_mask_q, ptr_mask_d;
  logic           lock_q, lock_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [WW-1:0]  credit_q, credit_d;

  logic [N-1:0]  masked_gnt, unmasked_gnt, rr_gnt;
  logic          owner_active, xfer, owner_drop;
  logic [WW-1:0] rem;
  logic [N-1:0]  above_g, above_owner;

  fixed_arbiter #(
    .N(N)
  ) u_masked_arb (
    .req_i(requests & ptr_mask_q),
    .gnt_o(masked_gnt)
  );

  fixed_arbiter #(
    .N(N)
  ) u_unmasked_arb (
    .req_i(requests),
    .gnt_o(unmasked_gnt)
  );

  always_comb begin
    owner_active = lock_q & requests[owner_q];
    rr_gnt       = (|masked_gnt) ? masked_gnt : unmasked_gnt;
    grants       = owner_active ? (N'(1) << owner_q) : rr_gnt;
    grant_valid  = |grants;
    grant_id     = IDW'(onehot_to_idx(MaxN'(grants)));
    xfer         = grant_valid & grant_ready;
    owner_drop   = lock_q & ~requests[owner_q];
    for (int i = 0; i < int'(N); i++) begin
      above_g[i]     = (i > int'(grant_id));
      above_owner[i] = (i > int'(owner_q));
    end
  end

  // Weight is only sampled when a tenure starts; continuing tenures burn credit.
  always_comb begin
    ptr_mask_d = ptr_mask_q;
    lock_d     = lock_q;
    owner_d    = owner_q;
    credit_d   = credit_q;
    rem        = '0;
    if (xfer) begin
      if (owner_active) begin
        rem = credit_q - WW'(1);
      end else begin
        rem = WW'(eff_weight(32'(weights[grant_id*WW +: WW])) - 1);
      end
      if (rem != '0) begin
        lock_d   = 1'b1;
        owner_d  = grant_id;
        credit_d = rem;
      end else begin
        lock_d     = 1'b0;
        ptr_mask_d = above_g;
      end
    end else if (owner_drop) begin
      lock_d     = 1'b0;
      ptr_mask_d = above_owner;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_mask_q <= '1;
      lock_q     <= 1'b0;
      owner_q    <= '0;
      credit_q   <= '0;
    end else begin
      ptr_mask_q <= ptr_mask_d;
      lock_q     <= lock_d;
      owner_q    <= owner_d;
      credit_q   <= credit_d;
    end
  end

endmodule

// File: tb/tb_weighted_round_robin_arbiter.sv
// Directed, table-driven bench for weighted_round_robin_arbiter at N=4, WW=4.
module tb_weighted_round_robin_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  requests;
  logic [15:0] weights;
  logic        grant_ready;
  logic [3:0]  grants;
  logic        grant_valid;
  logic [1:0]  grant_id;

  int n_checks;
  int n_fail;

  weighted_round_robin_arbiter #(
    .N (4),
    .WW(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .requests   (requests),
    .weights    (weights),
    .grant_ready(grant_ready),
    .grants     (grants),
    .grant_valid(grant_valid),
    .grant_id   (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic [3:0]  req;
    logic [15:0] w;
    logic        rdy;
    logic        chk;
    logic [3:0]  g;
    logic        v;
    logic [1:0]  id;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic [3:0] req, input logic [15:0] w,
                              input logic rdy, input logic chk, input logic [3:0] g,
                              input logic v, input logic [1:0] id);
    vecs.push_back('{rst: r, req: req, w: w, rdy: rdy, chk: chk, g: g, v: v, id: id});
  endfunction

  function automatic void add_rst();
    add(1'b1, 4'h0, 16'h0000, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0);
  endfunction

  // Inputs are driven after the falling edge and sampled 1 time unit later.
  task automatic step(input vec_t v, input string name);
    rst         = v.rst;
    requests    = v.req;
    weights     = v.w;
    grant_ready = v.rdy;
    #1;
    if (v.chk) begin
      n_checks++;
      if (grants !== v.g) begin
        n_fail++;
        $display("FAIL %s grants: got %b expected %b", name, grants, v.g);
      end
      n_checks++;
      if (grant_valid !== v.v) begin
        n_fail++;
        $display("FAIL %s grant_valid: got %b expected %b", name, grant_valid, v.v);
      end
      n_checks++;
      if (grant_id !== v.id) begin
        n_fail++;
        $display("FAIL %s grant_id: got %0d expected %0d", name, grant_id, v.id);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    requests    = '0;
    weights     = '0;
    grant_ready = 1'b0;

    // Reset with no requests.
    add_rst();
    add(1'b0, 4'h0, 16'h1111, 1'b0, 1'b1, 4'h0, 1'b0, 2'd0);
    // Equal weights rotate through all four and wrap.
    add_rst();
    add(1'b0, 4'hF, 16'h1111, 1'b1, 1'b1, 4'h1, 1'b1, 2'd0);
    add(1'b0, 4'hF, 16'h1111, 1'b1, 1'b1, 4'h2, 1'b1, 2'd1);
    add(1'b0, 4'hF, 16'h1111, 1'b1, 1'b1, 4'h4, 1'b1, 2'd2);
    add(1'b0, 4'hF, 16'h1111, 1'b1, 1'b1, 4'h8, 1'b1, 2'd3);
    add(1'b0, 4'hF, 16'h1111, 1'b1, 1'b1, 4'h1, 1'b1, 2'd0);
    // Unequal weights w0=2, w1=3.
    add_rst();
    add(1'b0, 4'h3, 16'h0032, 1'b1, 1'b1, 4'h1, 1'b1, 2'd0);
    add(1'b0, 4'h3, 16'h0032, 1'b1, 1'b1, 4'h1, 1'b1, 2'd0);
    add(1'b0, 4'h3, 16'h0032, 1'b1, 1'b1, 4'h2, 1'b1, 2'd1);
    add(1'b0, 4'h3, 16'h0032, 1'b1, 1'b1, 4'h2, 1'b1, 2'd1);
    add(1'b0, 4'h3, 16'h0032, 1'b1, 1'b1, 4'h2, 1'b1, 2'd1);
    add(1'b0, 4'h3, 16'h0032, 1'b1, 1'b1, 4'h1, 1'b1, 2'd0);
    add(1'b0, 4'h3, 16'h0032, 1'b1, 1'b1, 4'h1, 1'b1, 2'd0);
    // Backpressure holds the grant, then one accept rotates it.
    add_rst();
    add(1'b0, 4'h6, 16'h1111, 1'b0, 1'b1, 4'h2, 1'b1, 2'd1);
    add(1'b0, 4'h6, 16'h1111, 1'b0, 1'b1, 4'h2, 1'b1, 2'd1);
    add(1'b0, 4'h6, 16'h1111, 1'b0, 1'b1, 4'h2, 1'b1, 2'd1);
    add(1'b0, 4'h6, 16'h1111, 1'b1, 1'b1, 4'h2, 1'b1, 2'd1);
    add(1'b0, 4'h6, 16'h1111, 1'b0, 1'b1, 4'h4, 1'b1, 2'd2);
    // Owner drop with a same-cycle transfer to another requester.
    add_rst();
    add(1'b0, 4'h5, 16'h0004, 1'b1, 1'b1, 4'h1, 1'b1, 2'd0);
    add(1'b0, 4'h4, 16'h0004, 1'b1, 1'b1, 4'h4, 1'b1, 2'd2);
    add(1'b0, 4'h5, 16'h0004, 1'b1, 1'b1, 4'h1, 1'b1, 2'd0);
    add(1'b0, 4'h5, 16'h0004, 1'b1, 1'b1, 4'h1, 1'b1, 2'd0);
    add(1'b0, 4'h5, 16'h0004, 1'b1, 1'b1, 4'h1, 1'b1, 2'd0);
    add(1'b0, 4'h5, 16'h0004, 1'b1, 1'b1, 4'h1, 1'b1, 2'd0);
    add(1'b0, 4'h5, 16'h0004, 1'b1, 1'b1, 4'h4, 1'b1, 2'd2);
    // Owner drop with no transfer rotates the pointer past the owner.
    add_rst();
    add(1'b0, 4'h1, 16'h0004, 1'b1, 1'b1, 4'h1, 1'b1, 2'd0);
    add(1'b0, 4'h0, 16'h0004, 1'b0, 1'b1, 4'h0, 1'b0, 2'd0);
    add(1'b0, 4'h5, 16'h0004, 1'b0, 1'b1, 4'h4, 1'b1, 2'd2);
    // Weight 0 behaves as weight 1.
    add_rst();
    add(1'b0, 4'h3, 16'h0000, 1'b1, 1'b1, 4'h1, 1'b1, 2'd0);
    add(1'b0, 4'h3, 16'h0000, 1'b1, 1'b1, 4'h2, 1'b1, 2'd1);
    add(1'b0, 4'h3, 16'h0000, 1'b1, 1'b1, 4'h1, 1'b1, 2'd0);
    add(1'b0, 4'h3, 16'h0000, 1'b1, 1'b1, 4'h2, 1'b1, 2'd1);
    // Weight change mid-tenure is ignored.
    add_rst();
    add(1'b0, 4'h1, 16'h0002, 1'b1, 1'b1, 4'h1, 1'b1, 2'd0);
    add(1'b0, 4'h3, 16'h000F, 1'b1, 1'b1, 4'h1, 1'b1, 2'd0);
    add(1'b0, 4'h3, 16'h000F, 1'b1, 1'b1, 4'h2, 1'b1, 2'd1);

    @(negedge clk);
    foreach (vecs[i]) step(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of a weight-5 tenure on requester 1.
    begin
      vec_t v;
      add_rst();
      step(vecs[vecs.size()-1], "mid_rst_a");
      v = '{rst: 1'b0, req: 4'h2, w: 16'h0050, rdy: 1'b1, chk: 1'b1, g: 4'h2, v: 1'b1, id: 2'd1};
      step(v, "mid_rst_xfer1");
      step(v, "mid_rst_xfer2");
      v = '{rst: 1'b1, req: 4'h2, w: 16'h0050, rdy: 1'b1, chk: 1'b0, g: 4'h0, v: 1'b0, id: 2'd0};
      step(v, "mid_rst_pulse");
      v = '{rst: 1'b0, req: 4'hF, w: 16'h0050, rdy: 1'b1, chk: 1'b1, g: 4'h1, v: 1'b1, id: 2'd0};
      step(v, "mid_rst_fresh");
      v = '{rst: 1'b0, req: 4'hF, w: 16'h0050, rdy: 1'b1, chk: 1'b1, g: 4'h2, v: 1'b1, id: 2'd1};
      step(v, "mid_rst_next");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
